spike_decoder: RTL and testbench
================================

SPIKE_DECODER -- requirements
Module: spike_decoder

Interface
REQ-001 Parameter NUM_NEURONS, default 2: number of SNN output neurons observed.
REQ-002 Parameter WINDOW_CYCLES, default 1024: length of the spike-integration window, in clock cycles.
REQ-003 Parameter COUNT_W, default 8: width of each per-neuron spike counter.
REQ-004 iCLK  input  1: single clock (the 120 MHz SNN clock); all logic on its rising edge.
REQ-005 iRESETn  input  1: reset, asynchronous, active-low.
REQ-006 iSTART  input  1: single-cycle pulse marking the start of an SNN inference (the network's start strobe).
REQ-007 iSPIKE  input  NUM_NEURONS: per-neuron spike flags from the network output, sampled every cycle.
REQ-008 oBUSY  output  1: high while a window or comparison is in progress.
REQ-009 oVALID  output  1: one-cycle pulse when a new result is available.
REQ-010 oCLASS  output  max(1,$clog2(NUM_NEURONS)): index of the winning neuron, held until the next oVALID.
REQ-011 oCOUNT  output  COUNT_W: spike count of the winning neuron, held with oCLASS.
REQ-012 oTIE  output  1: winner's count equalled an earlier-compared count, held with oCLASS.
REQ-013 oNONE  output  1: all counts zero, held with oCLASS.

Function
REQ-014 FSM states: IDLE, COUNT, COMPARE, DONE.
REQ-015 IDLE: when iSTART=1, clear all counters and the window counter, and go to COUNT.
REQ-016 COUNT: each cycle, every counter i with iSPIKE[i]=1 increments by 1; the window counter increments.
REQ-017 Counters saturate at 2^COUNT_W-1 and never wrap.
REQ-018 COUNT lasts exactly WINDOW_CYCLES cycles, then the FSM enters COMPARE.
REQ-019 COMPARE scans one neuron per cycle, index 0 to NUM_NEURONS-1: NUM_NEURONS cycles.
REQ-020 Comparison rule: the best candidate is replaced only on strictly greater; ties resolve to the lowest index.
REQ-021 oTIE is set if any later-scanned count equals the current best.
REQ-022 After the last index, the FSM enters DONE.
REQ-023 DONE lasts one cycle: oCLASS/oCOUNT/oTIE/oNONE update, oVALID=1, then return to IDLE.
REQ-024 Latency: oVALID is asserted exactly WINDOW_CYCLES+NUM_NEURONS+1 cycles after the cycle in which iSTART was sampled.
REQ-025 oBUSY=1 in COUNT, COMPARE and DONE; 0 in IDLE.
REQ-026 iSTART during COUNT or COMPARE aborts the run: counters clear, re-enter COUNT, no oVALID for the aborted run.
REQ-027 iSTART in DONE: oVALID still pulses for the finished run, and the next cycle is COUNT with counters cleared.
REQ-028 iSPIKE is ignored outside COUNT.
REQ-029 oNONE=1 iff all counts are 0; oCLASS=0 and oCOUNT=0 in that case.
REQ-030 Result outputs do not change except in DONE.

Reset
REQ-031 iRESETn low forces, immediately: state IDLE, all counters 0, oBUSY=0, oVALID=0, oCLASS=0, oCOUNT=0, oTIE=0, oNONE=0.
REQ-032 Reset asserted mid-window discards the run; no oVALID follows reset release until a new iSTART.

Structure
REQ-033 Shared package snn_pkg holds the FSM state enum and default NUM_NEURONS/WINDOW_CYCLES/COUNT_W constants.
REQ-034 One sub-module, spike_counter (saturating counter with clear and enable), is instantiated NUM_NEURONS times.

Verification (NUM_NEURONS=2, WINDOW_CYCLES=16, COUNT_W=4)
REQ-035 iSTART, iSPIKE=2'b10 for all 16 cycles -> oVALID 19 cycles later, oCLASS=1, oCOUNT=15 (saturated), oTIE=0, oNONE=0.
REQ-036 iSTART, iSPIKE=2'b11 for 5 cycles then 0 -> oCLASS=0, oCOUNT=5, oTIE=1.
REQ-037 iSTART, iSPIKE=0 throughout -> oVALID, oNONE=1, oCLASS=0, oCOUNT=0.
REQ-038 iSTART; bit0 high for 10 cycles; second iSTART at cycle 8; then bit1 high 3 cycles -> one oVALID only, 19 cycles after the second start, oCLASS=1, oCOUNT=3.
REQ-039 iRESETn pulsed low at cycle 6 of a window -> all outputs 0 immediately; no oVALID afterwards without a new iSTART.
REQ-040 iSTART coincident with DONE -> oVALID pulses with the old result; new run yields oVALID 19 cycles later.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared definitions for the SNN output decoder: FSM state encoding and default sizing.
package snn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam int DEF_NUM_NEURONS   = 2;
    localparam int DEF_WINDOW_CYCLES = 1024;
    localparam int DEF_COUNT_W       = 8;

endpackage

// File: rtl/spike_counter.sv
// Per-neuron spike counter: synchronous clear wins over enable, saturates at all-ones.
module spike_counter #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    output logic [COUNT_W-1:0] count
);

    localparam logic [COUNT_W-1:0] CNT_MAX  = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] CNT_ZERO = {COUNT_W{1'b0}};

    logic [COUNT_W-1:0] count_d;
    logic [COUNT_W-1:0] count_q;

    // Next count: clear, saturating increment, or hold
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = CNT_ZERO;
        end else if (en && (count_q != CNT_MAX)) begin
            count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= CNT_ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/spike_decoder.sv
// Integrates SNN output spikes over a fixed window and reports the most active neuron.
module spike_decoder
    import snn_pkg::*;
#(
    parameter int NUM_NEURONS   = DEF_NUM_NEURONS,
    parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int COUNT_W       = DEF_COUNT_W,
    localparam int CLASS_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                   iCLK,
    input  logic                   iRESETn,
    input  logic                   iSTART,
    input  logic [NUM_NEURONS-1:0] iSPIKE,
    output logic                   oBUSY,
    output logic                   oVALID,
    output logic [CLASS_W-1:0]     oCLASS,
    output logic [COUNT_W-1:0]     oCOUNT,
    output logic                   oTIE,
    output logic                   oNONE
);

    localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [WIN_W-1:0]   WIN_ZERO  = {WIN_W{1'b0}};
    localparam logic [WIN_W-1:0]   WIN_ONE   = WIN_W'(1);
    localparam logic [CLASS_W-1:0] IDX_LAST  = CLASS_W'(NUM_NEURONS - 1);
    localparam logic [CLASS_W-1:0] IDX_ZERO  = {CLASS_W{1'b0}};
    localparam logic [CLASS_W-1:0] IDX_ONE   = CLASS_W'(1);
    localparam logic [COUNT_W-1:0] CNT_ZERO  = {COUNT_W{1'b0}};

    state_e               state_q, state_d;
    logic [WIN_W-1:0]     win_q, win_d;
    logic [CLASS_W-1:0]   idx_q, idx_d;
    logic [COUNT_W-1:0]   best_cnt_q, best_cnt_d;
    logic [CLASS_W-1:0]   best_idx_q, best_idx_d;
    logic                 best_tie_q, best_tie_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic [CLASS_W-1:0]   class_q, class_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 tie_q, tie_d;
    logic                 none_q, none_d;

    logic [COUNT_W-1:0]   cnt_s [NUM_NEURONS];
    logic [COUNT_W-1:0]   scan_cnt_s;
    logic [CLASS_W-1:0]   scan_idx_s;
    logic                 scan_tie_s;
    logic                 cnt_en_s;

    // A start strobe in any state restarts the window, so it always clears the counters
    assign cnt_en_s = (state_q == ST_COUNT) && !iSTART;

    for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_cnt
        spike_counter #(.COUNT_W(COUNT_W)) u_cnt (
            .clk   (iCLK),
            .rst_n (iRESETn),
            .clr   (iSTART),
            .en    (cnt_en_s && iSPIKE[i]),
            .count (cnt_s[i])
        );
    end

    // One scan step: replace best only on strictly greater; an equal later count flags a tie
    always_comb begin
        scan_cnt_s = best_cnt_q;
        scan_idx_s = best_idx_q;
        scan_tie_s = best_tie_q;
        if (idx_q == IDX_ZERO) begin
            scan_cnt_s = cnt_s[idx_q];
            scan_idx_s = idx_q;
            scan_tie_s = 1'b0;
        end else if (cnt_s[idx_q] > best_cnt_q) begin
            scan_cnt_s = cnt_s[idx_q];
            scan_idx_s = idx_q;
            scan_tie_s = 1'b0;
        end else if (cnt_s[idx_q] == best_cnt_q) begin
            scan_tie_s = 1'b1;
        end else begin
            scan_tie_s = best_tie_q;
        end
    end

    // FSM next state; results are loaded on the edge into DONE so oVALID is visible during DONE
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        idx_d      = idx_q;
        best_cnt_d = best_cnt_q;
        best_idx_d = best_idx_q;
        best_tie_d = best_tie_q;
        valid_d    = 1'b0;
        class_d    = class_q;
        count_d    = count_q;
        tie_d      = tie_q;
        none_d     = none_q;
        case (state_q)
            ST_IDLE: begin
                if (iSTART) begin
                    state_d = ST_COUNT;
                    win_d   = WIN_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (iSTART) begin
                    win_d = WIN_ZERO;
                end else if (win_q == WIN_LAST) begin
                    state_d = ST_COMPARE;
                    idx_d   = IDX_ZERO;
                end else begin
                    win_d = win_q + WIN_ONE;
                end
            end
            ST_COMPARE: begin
                if (iSTART) begin
                    state_d = ST_COUNT;
                    win_d   = WIN_ZERO;
                end else begin
                    best_cnt_d = scan_cnt_s;
                    best_idx_d = scan_idx_s;
                    best_tie_d = scan_tie_s;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                        valid_d = 1'b1;
                        class_d = scan_idx_s;
                        count_d = scan_cnt_s;
                        tie_d   = scan_tie_s;
                        none_d  = (scan_cnt_s == CNT_ZERO);
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            ST_DONE: begin
                if (iSTART) begin
                    state_d = ST_COUNT;
                    win_d   = WIN_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // FSM, scan and result registers
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state_q    <= ST_IDLE;
            win_q      <= WIN_ZERO;
            idx_q      <= IDX_ZERO;
            best_cnt_q <= CNT_ZERO;
            best_idx_q <= IDX_ZERO;
            best_tie_q <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            class_q    <= IDX_ZERO;
            count_q    <= CNT_ZERO;
            tie_q      <= 1'b0;
            none_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            idx_q      <= idx_d;
            best_cnt_q <= best_cnt_d;
            best_idx_q <= best_idx_d;
            best_tie_q <= best_tie_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            class_q    <= class_d;
            count_q    <= count_d;
            tie_q      <= tie_d;
            none_q     <= none_d;
        end
    end

    assign oBUSY  = busy_q;
    assign oVALID = valid_q;
    assign oCLASS = class_q;
    assign oCOUNT = count_q;
    assign oTIE   = tie_q;
    assign oNONE  = none_q;

endmodule

// File: tb/tb_spike_decoder.sv
// Scoreboard bench for spike_decoder with NUM_NEURONS=2, WINDOW_CYCLES=16, COUNT_W=4.
module tb_spike_decoder;

    localparam int N  = 2;
    localparam int W  = 16;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int LAT = W + N + 1;

    typedef struct {
        int due;
        int cls;
        int cnt;
        int tie;
        int none;
    } exp_t;

    logic          iCLK;
    logic          iRESETn;
    logic          iSTART;
    logic [N-1:0]  iSPIKE;
    logic          oBUSY;
    logic          oVALID;
    logic [0:0]    oCLASS;
    logic [CW-1:0] oCOUNT;
    logic          oTIE;
    logic          oNONE;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t q[$];

    int   run_active = 0;
    int   run_s      = 0;
    int   mcnt [N];
    logic exp_busy   = 1'b0;
    logic mon_en     = 1'b0;

    spike_decoder #(
        .NUM_NEURONS   (N),
        .WINDOW_CYCLES (W),
        .COUNT_W       (CW)
    ) dut (
        .iCLK    (iCLK),
        .iRESETn (iRESETn),
        .iSTART  (iSTART),
        .iSPIKE  (iSPIKE),
        .oBUSY   (oBUSY),
        .oVALID  (oVALID),
        .oCLASS  (oCLASS),
        .oCOUNT  (oCOUNT),
        .oTIE    (oTIE),
        .oNONE   (oNONE)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Winner = lowest index holding the maximum; tie when the maximum occurs more than once
    task automatic push_result(input int due);
        exp_t e;
        int mx, nmax;
        mx = 0;
        for (int i = 0; i < N; i++) if (mcnt[i] > mx) mx = mcnt[i];
        nmax = 0;
        e.cls = -1;
        for (int i = 0; i < N; i++) begin
            if (mcnt[i] == mx) begin
                nmax++;
                if (e.cls < 0) e.cls = i;
            end
        end
        e.due  = due;
        e.cnt  = mx;
        e.tie  = (nmax > 1) ? 1 : 0;
        e.none = (mx == 0) ? 1 : 0;
        q.push_back(e);
    endtask

    task automatic drive(input logic st, input logic [N-1:0] sp);
        int c, rel;
        @(posedge iCLK);
        #1;
        mon_en = 1'b1;
        c   = cyc;
        rel = c - run_s;
        exp_busy = (run_active != 0) && (rel >= 1) && (rel <= LAT);
        if (run_active != 0 && rel == LAT) begin
            push_result(c);
            run_active = 0;
        end
        if (run_active != 0 && rel >= 1 && rel <= W) begin
            for (int i = 0; i < N; i++)
                if (sp[i] && mcnt[i] < CMAX) mcnt[i]++;
        end
        if (st) begin
            run_active = 1;
            run_s = c;
            for (int i = 0; i < N; i++) mcnt[i] = 0;
        end
        iSTART = st;
        iSPIKE = sp;
    endtask

    task automatic idle(input int n, input logic [N-1:0] sp);
        for (int i = 0; i < n; i++) drive(1'b0, sp);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_busy"},  int'(oBUSY),  0);
        check_eq({tag, "_valid"}, int'(oVALID), 0);
        check_eq({tag, "_class"}, int'(oCLASS), 0);
        check_eq({tag, "_count"}, int'(oCOUNT), 0);
        check_eq({tag, "_tie"},   int'(oTIE),   0);
        check_eq({tag, "_none"},  int'(oNONE),  0);
    endtask

    task automatic do_reset();
        @(posedge iCLK);
        #1;
        iRESETn = 1'b0;
        iSTART  = 1'b0;
        iSPIKE  = '0;
        run_active = 0;
        exp_busy   = 1'b0;
        q.delete();
        #1;
        check_zero_outputs("midrst");
        #2;
        iRESETn = 1'b1;
    endtask

    // Output monitor: sampled on the falling edge, compared against the scoreboard
    always @(negedge iCLK) begin
        if (mon_en && iRESETn) begin
            check_eq("busy", int'(oBUSY), int'(exp_busy));
            if (oVALID) begin
                if (q.size() == 0) begin
                    check_eq("spurious_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check_eq("valid_cycle", cyc, e.due);
                    check_eq("class", int'(oCLASS), e.cls);
                    check_eq("count", int'(oCOUNT), e.cnt);
                    check_eq("tie",   int'(oTIE),   e.tie);
                    check_eq("none",  int'(oNONE),  e.none);
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                check_eq("missing_valid", 0, 1);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) mcnt[i] = 0;
        iRESETn = 1'b0;
        iSTART  = 1'b0;
        iSPIKE  = '0;
        #3;
        check_zero_outputs("reset");
        @(negedge iCLK);
        iRESETn = 1'b1;
        idle(3, 2'b11);

        // Neuron 1 fires every cycle: saturates at 15
        drive(1'b1, 2'b00);
        idle(W, 2'b10);
        idle(6, 2'b00);

        // Both fire 5 cycles: tie resolved to index 0
        drive(1'b1, 2'b00);
        idle(5, 2'b11);
        idle(W - 5, 2'b00);
        idle(6, 2'b00);

        // Silent window; spikes outside the window are ignored
        drive(1'b1, 2'b11);
        idle(W, 2'b00);
        idle(6, 2'b11);

        // Restart at cycle 8 aborts the first run
        drive(1'b1, 2'b00);
        idle(7, 2'b01);
        drive(1'b1, 2'b01);
        idle(2, 2'b01);
        idle(3, 2'b10);
        idle(LAT, 2'b00);

        // Reset in the middle of a window discards it
        drive(1'b1, 2'b00);
        idle(5, 2'b11);
        do_reset();
        idle(LAT + 6, 2'b11);

        // Start coincident with DONE
        drive(1'b1, 2'b00);
        idle(W, 2'b01);
        idle(N, 2'b00);
        drive(1'b1, 2'b00);
        idle(4, 2'b10);
        idle(W - 4, 2'b00);
        idle(6, 2'b00);

        // Random spikes with occasional restarts
        drive(1'b1, 2'b00);
        for (int i = 0; i < 150; i++)
            drive(($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0, N'($urandom_range(0, 3)));
        idle(LAT + 4, 2'b00);

        check_eq("pending_results", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
